// File: rtl/alm_pkg.sv
// Shared width helpers and lane-field packing constants for the ALM pre-approximation pipe.
package alm_pkg;

  localparam int unsigned DefABw   = 32;
  localparam int unsigned DefLanes = 4;

  function automatic int unsigned log2_w(input int unsigned a_bw);
    return $clog2(a_bw);
  endfunction

  function automatic int unsigned log_bw(input int unsigned a_bw, input int unsigned frac_bw);
    return log2_w(a_bw) + frac_bw;
  endfunction

  // LSB of field idx in a bus made of equal-width fields.
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/alm_lane_log.sv
// One lane: leading-one encode in S1, fraction alignment in S2.
// Optional half-up rounding of the fraction when ALM_PRE_ROUND_EN is defined.
module alm_lane_log #(
  parameter int unsigned A_BW    = 32,
  parameter int unsigned FRAC_BW = 31,
  parameter int unsigned LOG2_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s1_load,
  input  logic               s2_load,
  input  logic [A_BW-1:0]    a,
  output logic [LOG2_W-1:0]  k,
  output logic [FRAC_BW-1:0] frac,
  output logic               zero
);

  localparam int unsigned Drop = A_BW - 1 - FRAC_BW;

  logic [LOG2_W-1:0]  k_enc, k1_q, k2_q;
  logic               zero1_q, zero2_q;
  logic [A_BW-1:0]    a1_q;
  logic [LOG2_W-1:0]  shamt;
  logic [A_BW-2:0]    aligned;
  logic [FRAC_BW-1:0] trunc, frac_c, frac2_q;

  always_comb begin
    k_enc = '0;
    for (int unsigned i = 0; i < A_BW; i++) begin
      if (a[i]) k_enc = LOG2_W'(i);
    end
  end

  // Shifting the leading one to bit A_BW-1 and dropping it leaves the fraction left-aligned.
  always_comb begin
    shamt   = LOG2_W'(A_BW - 1) - k1_q;
    aligned = (A_BW-1)'(a1_q << shamt);
    trunc   = FRAC_BW'(aligned >> Drop);
  end

`ifdef ALM_PRE_ROUND_EN
  if (Drop > 0) begin : g_round
    logic [FRAC_BW:0] sum;
    assign sum    = {1'b0, trunc} + {{FRAC_BW{1'b0}}, aligned[Drop-1]};
    assign frac_c = sum[FRAC_BW] ? '1 : sum[FRAC_BW-1:0];
  end else begin : g_trunc
    assign frac_c = trunc;
  end
`else
  assign frac_c = trunc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k1_q    <= '0;
      zero1_q <= 1'b0;
      a1_q    <= '0;
      k2_q    <= '0;
      frac2_q <= '0;
      zero2_q <= 1'b0;
    end else begin
      if (s1_load) begin
        k1_q    <= k_enc;
        zero1_q <= ~|a;
        a1_q    <= a;
      end
      if (s2_load) begin
        k2_q    <= k1_q;
        frac2_q <= frac_c;
        zero2_q <= zero1_q;
      end
    end
  end

  assign k    = k2_q;
  assign frac = frac2_q;
  assign zero = zero2_q;

endmodule

// File: rtl/alm_pre_approx_pipe.sv
// Two-stage, multi-lane log pre-approximation with valid/ready flow control.
// Build macro ALM_PRE_ROUND_EN enables fraction rounding in every lane.
module alm_pre_approx_pipe
  import alm_pkg::*;
#(
  parameter int unsigned  A_BW    = DefABw,
  parameter int unsigned  LANES   = DefLanes,
  parameter int unsigned  FRAC_BW = A_BW - 1,
  localparam int unsigned LOG2_W  = log2_w(A_BW),
  localparam int unsigned LOG_BW  = log_bw(A_BW, FRAC_BW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*A_BW-1:0]   in_a,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LOG_BW-1:0] out_log,
  output logic [LANES-1:0]        out_zero
);

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_load, s1_adv, out_fire;

  always_comb begin
    out_fire   = s2_valid_q && out_ready;
    s1_adv     = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready   = !s1_valid_q || s1_adv;
    s1_load    = in_valid && in_ready;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_load)       s1_valid_d = 1'b1;
    else if (s1_adv)   s1_valid_d = 1'b0;
    if (s1_adv)        s2_valid_d = 1'b1;
    else if (out_fire) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid = s2_valid_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LOG2_W-1:0]  k;
    logic [FRAC_BW-1:0] frac;

    alm_lane_log #(
      .A_BW    (A_BW),
      .FRAC_BW (FRAC_BW),
      .LOG2_W  (LOG2_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_load (s1_load),
      .s2_load (s1_adv),
      .a       (in_a[field_lsb(i, A_BW) +: A_BW]),
      .k       (k),
      .frac    (frac),
      .zero    (out_zero[i])
    );

    assign out_log[field_lsb(i, LOG_BW) +: LOG_BW] = {k, frac};
  end

endmodule

// File: tb/tb_alm_pre_approx_pipe.sv
// Self-checking bench: two instances (FRAC_BW=7 and FRAC_BW=4) against an arithmetic model.
module tb_alm_pre_approx_pipe;

  localparam int unsigned FracA = 7;
  localparam int unsigned FracB = 4;
`ifdef ALM_PRE_ROUND_EN
  localparam bit RoundB = 1'b1;
`else
  localparam bit RoundB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_a = '0;
  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [19:0] out_log_a;
  logic [13:0] out_log_b;
  logic [1:0]  out_zero_a, out_zero_b;
  int          n_vec = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alm_pre_approx_pipe #(.A_BW(8), .LANES(2), .FRAC_BW(FracA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_a(in_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_log(out_log_a), .out_zero(out_zero_a)
  );

  alm_pre_approx_pipe #(.A_BW(8), .LANES(2), .FRAC_BW(FracB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_a(in_a),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_log(out_log_b), .out_zero(out_zero_b)
  );

  // k = floor(log2 x); frac = floor((x/2^k - 1) * 2^fbw), optionally rounded half-up.
  function automatic int unsigned ref_lane(input int unsigned x, input int unsigned fbw,
                                           input bit rnd);
    int unsigned k, rem, f;
    if (x == 0) return 0;
    k = 0;
    while ((x >> (k + 1)) != 0) k++;
    rem = x - (1 << k);
    if (rnd) begin
      f = ((rem << (fbw + 1)) >> k);
      f = (f + 1) >> 1;
      if (f > (1 << fbw) - 1) f = (1 << fbw) - 1;
    end else begin
      f = (rem << fbw) >> k;
    end
    return (k << fbw) | f;
  endfunction

  function automatic logic [19:0] exp_a(input logic [15:0] v);
    return {10'(ref_lane(32'(v[15:8]), FracA, 1'b0)), 10'(ref_lane(32'(v[7:0]), FracA, 1'b0))};
  endfunction

  function automatic logic [13:0] exp_b(input logic [15:0] v);
    return {7'(ref_lane(32'(v[15:8]), FracB, RoundB)), 7'(ref_lane(32'(v[7:0]), FracB, RoundB))};
  endfunction

  function automatic logic [1:0] exp_z(input logic [15:0] v);
    return {v[15:8] == 8'h00, v[7:0] == 8'h00};
  endfunction

  function automatic logic [15:0] rand_vec();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 5) == 0) v[7:0] = 8'h00;
    if ($urandom_range(0, 5) == 0) v[15:8] = 8'h01;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b want 0/0", out_valid_a, out_valid_b);
    end
    n_vec++;
    if (out_log_a !== '0 || out_zero_a !== '0 || out_log_b !== '0 || out_zero_b !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %b %h %b want zeros", out_log_a, out_zero_a,
               out_log_b, out_zero_b);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready_a, in_ready_b);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vecs [2];
    logic [19:0] want [2];
    logic [1:0]  wz [2];
    vecs = '{16'h002C, 16'hFF01};
    want = '{{10'h000, 10'h2B0}, {10'h3FF, 10'h000}};
    wz   = '{2'b10, 2'b00};
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); in_valid = 1'b1; in_a = vecs[j]; out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0; #1;
      n_vec++;
      if (out_valid_a !== 1'b0) begin
        n_fail++; $display("FAIL latency_early[%0d]: got %b want 0", j, out_valid_a);
      end
      @(negedge clk); #1;
      n_vec++;
      if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1) begin
        n_fail++; $display("FAIL latency[%0d]: got %b/%b want 1/1", j, out_valid_a, out_valid_b);
      end
      n_vec++;
      if (out_log_a !== want[j] || out_zero_a !== wz[j]) begin
        n_fail++;
        $display("FAIL directed_a[%0d]: got %h/%b want %h/%b", j, out_log_a, out_zero_a,
                 want[j], wz[j]);
      end
      n_vec++;
      if (out_log_b !== exp_b(vecs[j]) || out_zero_b !== wz[j]) begin
        n_fail++;
        $display("FAIL directed_b[%0d]: got %h/%b want %h/%b", j, out_log_b, out_zero_b,
                 exp_b(vecs[j]), wz[j]);
      end
    end
  endtask

  task automatic test_round();
    logic [6:0] want0, want1;
    want0 = {3'd5, (RoundB ? 4'h8 : 4'h7)};
    want1 = {3'd5, 4'hF};
    @(negedge clk); in_valid = 1'b1; in_a = 16'h3F2F; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (out_valid_b !== 1'b1 || out_log_b[6:0] !== want0) begin
      n_fail++; $display("FAIL round_2f: got %b/%h want 1/%h", out_valid_b, out_log_b[6:0], want0);
    end
    n_vec++;
    if (out_log_b[13:7] !== want1) begin
      n_fail++; $display("FAIL round_3f: got %h want %h", out_log_b[13:7], want1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vec [10];
    logic [15:0] pend [$];
    logic [15:0] v;
    logic [19:0] held_a;
    logic [13:0] held_b;
    logic        exp_rdy;
    bit          stalled;
    int          sent, got;
    sent = 0; got = 0; stalled = 1'b0; held_a = '0; held_b = '0;
    for (int j = 0; j < 10; j++) vec[j] = rand_vec();
    for (int c = 1; c <= 40 && got < 10; c++) begin
      @(negedge clk);
      in_valid  = (sent < 10);
      if (sent < 10) in_a = vec[sent];
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (stalled) begin
        n_vec++;
        if (out_valid_a !== 1'b1 || out_log_a !== held_a || out_log_b !== held_b) begin
          n_fail++;
          $display("FAIL b2b_hold c%0d: got %b %h %h want 1 %h %h", c, out_valid_a, out_log_a,
                   out_log_b, held_a, held_b);
        end
      end
      exp_rdy = (pend.size() < 2) || out_ready;
      n_vec++;
      if (in_ready_a !== exp_rdy || in_ready_b !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_in_ready c%0d: got %b/%b want %b", c, in_ready_a, in_ready_b, exp_rdy);
      end
      if (out_valid_a === 1'b1 && out_ready) begin
        n_vec++;
        if (pend.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious c%0d: got out_valid 1 want 0", c);
        end else begin
          v = pend.pop_front();
          if (out_log_a !== exp_a(v) || out_zero_a !== exp_z(v) || out_log_b !== exp_b(v)) begin
            n_fail++;
            $display("FAIL b2b_data c%0d: got %h/%b/%h want %h/%b/%h", c, out_log_a, out_zero_a,
                     out_log_b, exp_a(v), exp_z(v), exp_b(v));
          end
        end
        got++;
      end
      stalled = (out_valid_a === 1'b1) && !out_ready;
      held_a  = out_log_a;
      held_b  = out_log_b;
      if (in_valid && in_ready_a === 1'b1) begin
        pend.push_back(in_a);
        sent++;
      end
    end
    n_vec++;
    if (got != 10 || pend.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d emitted want 10", got);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [15:0] pend [$];
    logic [15:0] v;
    logic        exp_rdy;
    int          sent, got;
    sent = 0; got = 0;
    v = rand_vec();
    for (int c = 0; c < 600 && got < 60; c++) begin
      @(negedge clk);
      in_valid  = (sent < 60) && ($urandom_range(0, 9) < 7);
      in_a      = v;
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_rdy = (pend.size() < 2) || out_ready;
      n_vec++;
      if (in_ready_a !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready_a, exp_rdy);
      end
      if (out_valid_a === 1'b1 && out_ready) begin
        n_vec++;
        if (pend.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious c%0d: got out_valid 1 want 0", c);
        end else begin
          logic [15:0] e;
          e = pend.pop_front();
          if (out_log_a !== exp_a(e) || out_zero_a !== exp_z(e) || out_log_b !== exp_b(e) ||
              out_zero_b !== exp_z(e)) begin
            n_fail++;
            $display("FAIL rnd_data c%0d: got %h/%b/%h want %h/%b/%h", c, out_log_a, out_zero_a,
                     out_log_b, exp_a(e), exp_z(e), exp_b(e));
          end
        end
        got++;
      end
      if (in_valid && in_ready_a === 1'b1) begin
        pend.push_back(in_a);
        sent++;
        v = rand_vec();
      end
    end
    n_vec++;
    if (got != 60 || pend.size() != 0) begin
      n_fail++; $display("FAIL rnd_count: got %0d emitted want 60", got);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_a = rand_vec();
    @(negedge clk); in_a = rand_vec();
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_valid: got %b/%b want 0/0", out_valid_a, out_valid_b);
    end
    n_vec++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_ready: got %b/%b want 1/1", in_ready_a, in_ready_b);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_leak c%0d: got %b/%b want 0/0", c, out_valid_a, out_valid_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round();
    test_back_to_back();
    test_random_traffic();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
